// File: rtl/riscv_mc_pkg.sv
// Shared encodings for the multicycle RISC-V control unit.
//   state_e          : 4-bit FSM state encoding (S0_FETCH..S8_BRANCH)
//   OP_*             : 7-bit major opcodes recognised by the decoder
//   ALUOP_*          : ALU control class handed to the ALU decoder
//   SRCB_*           : ALU operand B mux selects
package riscv_mc_pkg;

    typedef enum logic [3:0] {
        S0_FETCH    = 4'd0,
        S1_DECODE   = 4'd1,
        S2_MEMADR   = 4'd2,
        S3_MEMREAD  = 4'd3,
        S4_MEMWB    = 4'd4,
        S5_MEMWRITE = 4'd5,
        S6_EXECUTE  = 4'd6,
        S7_ALUWB    = 4'd7,
        S8_BRANCH   = 4'd8
    } state_e;

    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_SW    = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_REG   = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_BROFF = 2'b11;

endpackage

// File: rtl/multicycle_control_fsm.sv
// Main control unit of a multicycle RISC-V datapath (shared memory,
// IR/MDR/A/B/ALUOut registers). Moore FSM: every output is a function of
// the current state only; opcode only steers the next state.
// Ports:
//   clk, reset        : clock, asynchronous active-high reset (-> FETCH)
//   opcode[6:0]       : instr[6:0] from the instruction register
//   RegWrite, MemRead, MemWrite, IRWrite, PCWrite, PCWriteCond : enables
//   ALUSrcA, MemtoReg, IorD, PCSource, ALUOp[1:0], ALUSrcB[1:0] : selects
module multicycle_control_fsm
    import riscv_mc_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] opcode,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       MemtoReg,
    output logic       IorD,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       PCSource,
    output logic [1:0] ALUOp,
    output logic [1:0] ALUSrcB
);

    state_e state_q, state_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S0_FETCH;
        else       state_q <= state_d;
    end

    // Next state. Plain case (not casez): an X/Z opcode matches no item and
    // falls back to FETCH.
    always_comb begin
        state_d = S0_FETCH;
        case (state_q)
            S0_FETCH:  state_d = S1_DECODE;
            S1_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: state_d = S2_MEMADR;
                    OP_RTYPE:     state_d = S6_EXECUTE;
                    OP_BEQ:       state_d = S8_BRANCH;
                    default:      state_d = S0_FETCH;
                endcase
            end
            // Opcode is re-examined here to split loads from stores.
            S2_MEMADR: begin
                case (opcode)
                    OP_LW:   state_d = S3_MEMREAD;
                    OP_SW:   state_d = S5_MEMWRITE;
                    default: state_d = S0_FETCH;
                endcase
            end
            S3_MEMREAD: state_d = S4_MEMWB;
            S6_EXECUTE: state_d = S7_ALUWB;
            default:    state_d = S0_FETCH;
        endcase
    end

    // Moore outputs; everything not named for a state stays 0.
    always_comb begin
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        MemtoReg    = 1'b0;
        IorD        = 1'b0;
        IRWrite     = 1'b0;
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        PCSource    = 1'b0;
        ALUOp       = ALUOP_ADD;
        ALUSrcB     = SRCB_REG;
        case (state_q)
            S0_FETCH: begin
                // Read instruction at PC, load IR, PC <= PC + 4.
                MemRead = 1'b1;
                IRWrite = 1'b1;
                PCWrite = 1'b1;
                ALUSrcB = SRCB_FOUR;
            end
            S1_DECODE: begin
                // Speculatively compute the branch target into ALUOut.
                ALUSrcB = SRCB_BROFF;
            end
            S2_MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
            end
            S3_MEMREAD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
            end
            S4_MEMWB: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
            end
            S5_MEMWRITE: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
            end
            S6_EXECUTE: begin
                ALUSrcA = 1'b1;
                ALUOp   = ALUOP_FUNCT;
            end
            S7_ALUWB: begin
                RegWrite = 1'b1;
            end
            S8_BRANCH: begin
                // Compare A-B; on Zero the PC takes the target held in ALUOut.
                ALUSrcA     = 1'b1;
                ALUOp       = ALUOP_SUB;
                PCWriteCond = 1'b1;
                PCSource    = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Self-checking bench for multicycle_control_fsm: table-driven opcode
// sequences through a scoreboard queue, plus hand-written reset corners.
module tb_multicycle_control_fsm;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] opcode;
    logic       RegWrite, ALUSrcA, MemRead, MemWrite, MemtoReg, IorD;
    logic       IRWrite, PCWrite, PCWriteCond, PCSource;
    logic [1:0] ALUOp, ALUSrcB;

    multicycle_control_fsm dut (
        .clk(clk), .reset(reset), .opcode(opcode),
        .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .MemRead(MemRead),
        .MemWrite(MemWrite), .MemtoReg(MemtoReg), .IorD(IorD),
        .IRWrite(IRWrite), .PCWrite(PCWrite), .PCWriteCond(PCWriteCond),
        .PCSource(PCSource), .ALUOp(ALUOp), .ALUSrcB(ALUSrcB)
    );

    always #5 clk = ~clk;

    // Output word: {RegWrite, ALUSrcA, MemRead, MemWrite, MemtoReg, IorD,
    //               IRWrite, PCWrite, PCWriteCond, PCSource, ALUOp, ALUSrcB}
    localparam logic [13:0] E_FETCH  = 14'b0_0_1_0_0_0_1_1_0_0_00_01;
    localparam logic [13:0] E_DEC    = 14'b0_0_0_0_0_0_0_0_0_0_00_11;
    localparam logic [13:0] E_ADR    = 14'b0_1_0_0_0_0_0_0_0_0_00_10;
    localparam logic [13:0] E_MRD    = 14'b0_0_1_0_0_1_0_0_0_0_00_00;
    localparam logic [13:0] E_MWB    = 14'b1_0_0_0_1_0_0_0_0_0_00_00;
    localparam logic [13:0] E_MWR    = 14'b0_0_0_1_0_1_0_0_0_0_00_00;
    localparam logic [13:0] E_EXE    = 14'b0_1_0_0_0_0_0_0_0_0_10_00;
    localparam logic [13:0] E_AWB    = 14'b1_0_0_0_0_0_0_0_0_0_00_00;
    localparam logic [13:0] E_BR     = 14'b0_1_0_0_0_0_0_0_1_1_01_00;

    localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011;
    localparam logic [6:0] RT = 7'b0110011, BQ = 7'b1100011;
    localparam logic [6:0] BAD = 7'b1111111;

    typedef struct {
        logic [6:0]  op;
        logic [13:0] exp;   // outputs after the next rising edge
        string       name;
    } vec_t;

    vec_t        vecs[32];
    int          nv = 0;
    logic [13:0] sb_q[$];
    int          tests = 0, fails = 0;

    function automatic logic [13:0] outs();
        return {RegWrite, ALUSrcA, MemRead, MemWrite, MemtoReg, IorD,
                IRWrite, PCWrite, PCWriteCond, PCSource, ALUOp, ALUSrcB};
    endfunction

    task automatic check(input string name, input logic [13:0] exp);
        logic [13:0] act;
        act = outs();
        tests++;
        // Expected words already encode the exclusivity rules; flag a
        // violation even if the word comparison happens to be skipped.
        if (act !== exp || (act[11] && act[10]) || (act[6] && act[5])) begin
            fails++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic add(input logic [6:0] op, input logic [13:0] exp, input string name);
        vecs[nv].op   = op;
        vecs[nv].exp  = exp;
        vecs[nv].name = name;
        nv++;
    endtask

    initial begin
        // lw: S0 S1 S2 S3 S4 S0
        add(LW, E_DEC, "lw_dec");  add(LW, E_ADR, "lw_adr");
        add(LW, E_MRD, "lw_mrd");  add(LW, E_MWB, "lw_mwb");
        add(LW, E_FETCH, "lw_fetch");
        // sw: S0 S1 S2 S5 S0
        add(SW, E_DEC, "sw_dec");  add(SW, E_ADR, "sw_adr");
        add(SW, E_MWR, "sw_mwr");  add(SW, E_FETCH, "sw_fetch");
        // R-type: S0 S1 S6 S7 S0
        add(RT, E_DEC, "r_dec");   add(RT, E_EXE, "r_exe");
        add(RT, E_AWB, "r_awb");   add(RT, E_FETCH, "r_fetch");
        // beq: S0 S1 S8 S0
        add(BQ, E_DEC, "beq_dec"); add(BQ, E_BR, "beq_br");
        add(BQ, E_FETCH, "beq_fetch");
        // illegal opcode in decode returns to fetch
        add(BAD, E_DEC, "bad_dec"); add(BAD, E_FETCH, "bad_fetch");
        // opcode no longer lw/sw when leaving MEMADR -> fetch
        add(LW, E_DEC, "redir_dec"); add(LW, E_ADR, "redir_adr");
        add(RT, E_FETCH, "redir_fetch");

        // Reset: asserted asynchronously between edges.
        opcode = 7'd0;
        reset  = 1'b0;
        #2 reset = 1'b1;
        #1 check("reset_async", E_FETCH);
        repeat (2) @(posedge clk);
        #1 check("reset_held", E_FETCH);
        @(negedge clk) reset = 1'b0;
        @(posedge clk);
        #1 check("post_reset_dec", E_DEC);
        @(posedge clk);
        #1 check("post_reset_fetch", E_FETCH);   // opcode 0 is illegal

        // Table vectors through the scoreboard.
        for (int i = 0; i < nv; i++) begin
            opcode = vecs[i].op;
            sb_q.push_back(vecs[i].exp);
            @(posedge clk);
            #1;
            if (sb_q.size() == 0) begin
                tests++; fails++;
                $display("FAIL %s: scoreboard empty", vecs[i].name);
            end else begin
                check(vecs[i].name, sb_q.pop_front());
            end
        end

        // Partially unknown opcode in decode: no legal opcode matches any
        // resolution of these bits, so the next state is fetch.
        opcode = LW;
        @(posedge clk); #1 check("x_dec", E_DEC);
        opcode = 7'b1x1x1x1;
        @(posedge clk); #1 check("x_fetch", E_FETCH);

        // Reset pulsed mid-cycle while in MEMREAD.
        opcode = LW;
        @(posedge clk); #1 check("mid_dec", E_DEC);
        @(posedge clk); #1 check("mid_adr", E_ADR);
        @(posedge clk); #1 check("mid_mrd", E_MRD);
        #2 reset = 1'b1;
        #1 check("mid_reset_async", E_FETCH);
        #1 reset = 1'b0;
        @(posedge clk); #1 check("mid_after_dec", E_DEC);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
